// File: rtl/div_seq32.sv
// Sequential restoring divider: one shared (WIDTH+1)-bit subtractor, WIDTH iterations per quotient.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module div_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_negq;
  logic             r_negr;
  logic             r_exc;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_d;

`ifdef DIV_SIGNED_EN
  assign w_a_neg = data_operandA[WIDTH-1];
  assign w_b_neg = data_operandB[WIDTH-1];
  assign w_a_mag = w_a_neg ? -data_operandA : data_operandA;
  assign w_b_mag = w_b_neg ? -data_operandB : data_operandB;
  assign w_ovf   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
`else
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
  assign w_a_mag = data_operandA;
  assign w_b_mag = data_operandB;
  assign w_ovf   = 1'b0;
`endif

  assign w_div0 = (data_operandB == '0);

  // Partial remainder always stays below the divisor, so WIDTH bits hold it between steps.
  assign w_shr = {r_rem, r_quo[WIDTH-1]};
  assign w_d   = w_shr - {1'b0, r_divisor};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (ctrl_DIV) begin
      w_next = (w_div0 || w_ovf) ? S_DONE : S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (r_cnt == CW'(WIDTH-1)) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // Exception cases preload quotient/remainder with their final values so the
  // DONE write path is shared with normal divisions.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_divisor      <= '0;
      r_negq         <= 1'b0;
      r_negr         <= 1'b0;
      r_exc          <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        r_cnt     <= '0;
        r_divisor <= w_b_mag;
        if (w_div0) begin
          r_rem  <= data_operandA;
          r_quo  <= '0;
          r_negq <= 1'b0;
          r_negr <= 1'b0;
          r_exc  <= 1'b1;
        end else if (w_ovf) begin
          r_rem  <= '0;
          r_quo  <= {1'b1, {(WIDTH-1){1'b0}}};
          r_negq <= 1'b0;
          r_negr <= 1'b0;
          r_exc  <= 1'b1;
        end else begin
          r_rem  <= '0;
          r_quo  <= w_a_mag;
          r_negq <= w_a_neg ^ w_b_neg;
          r_negr <= w_a_neg;
          r_exc  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_d[WIDTH] ? w_shr[WIDTH-1:0] : w_d[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_d[WIDTH]};
          end
          S_DONE: begin
            data_result    <= r_negq ? -r_quo : r_quo;
            data_remainder <= r_negr ? -r_rem : r_rem;
            data_exception <= r_exc;
            data_resultRDY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq32.sv
// Scoreboard bench for div_seq32: expected results and RDY edges are queued at each start.
module tb_div_seq32;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          rdy_at;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;

  exp_t        sbq[$];
  int          edge_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_rdy = 1'b0;
  logic [31:0] last_res = '0;
  logic [31:0] last_rem = '0;

  div_seq32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int e0);
    exp_t e;
    if (b == 32'd0) begin
      e.res = 32'd0; e.rem = a; e.exc = 1'b1; e.rdy_at = e0 + 1;
`ifdef DIV_SIGNED_EN
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.rem = 32'd0; e.exc = 1'b1; e.rdy_at = e0 + 1;
    end else begin
      int sa, sb;
      sa = a; sb = b;
      e.res = sa / sb; e.rem = sa % sb; e.exc = 1'b0; e.rdy_at = e0 + 33;
`else
    end else begin
      e.res = a / b; e.rem = a % b; e.exc = 1'b0; e.rdy_at = e0 + 33;
`endif
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n === 1'b1 && data_resultRDY === 1'b1) begin
      chk("rdy_gap", {31'd0, prev_rdy}, 32'd0);
      if (sbq.size() == 0) begin
        chk("rdy_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rdy_edge", edge_cnt, e.rdy_at);
        chk("result", data_result, e.res);
        chk("remainder", data_remainder, e.rem);
        chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
        last_res = e.res;
        last_rem = e.rem;
      end
    end
    prev_rdy = data_resultRDY;
  end

  // A start sampled on edge E0 pre-empts any RDY that would have landed on E0 or later.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input int unsigned hold = 1);
    for (int unsigned i = 0; i < hold; i++) begin
      int e0;
      @(negedge clock); #2;
      ctrl_DIV = 1'b1;
      data_operandA = a;
      data_operandB = b;
      e0 = edge_cnt + 1;
      while (sbq.size() > 0 && sbq[$].rdy_at >= e0) void'(sbq.pop_back());
      sbq.push_back(model(a, b, e0));
    end
    @(negedge clock); #2;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain(input int unsigned limit);
    for (int unsigned i = 0; i < limit && sbq.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    chk("drain", sbq.size(), 32'd0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1 reset_n = 1'b0;
    idle(3);
    chk("reset_result", data_result, 32'd0);
    chk("reset_remainder", data_remainder, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    #2 reset_n = 1'b1;

    start(32'd100, 32'd7);
    wait_drain(60);
    start(32'd55, 32'd0);
    wait_drain(10);
`ifdef DIV_SIGNED_EN
    start(-32'sd100, 32'd7);
    wait_drain(60);
    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain(10);
    start(32'd100, -32'sd7);
    wait_drain(60);
    start(32'h8000_0000, 32'd1);
    wait_drain(60);
`else
    start(32'hFFFF_FFFF, 32'h10);
    wait_drain(60);
    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain(60);
`endif
    start(32'd5, 32'd9);
    wait_drain(60);
    start(32'h1234_5678, 32'h1234_5678);
    wait_drain(60);
    start(32'hDEAD_BEEF, 32'd1);
    wait_drain(60);

    // Outputs hold the previous result through a following RUN.
    start(32'd1000, 32'd10);
    idle(5);
    chk("hold_result", data_result, last_res);
    chk("hold_remainder", data_remainder, last_rem);
    wait_drain(60);

    // Restart mid-RUN: first division abandoned, RDY 33 edges after the second start.
    start(32'd100, 32'd7);
    idle(8);
    start(32'd9, 32'd3);
    wait_drain(60);

    // Restart on the DONE-exit edge suppresses that RDY.
    start(32'd77, 32'd5);
    idle(31);
    start(32'd40, 32'd6);
    wait_drain(60);

    // Back-to-back: start right after a RDY, and a multi-cycle held start.
    start(32'd81, 32'd0);
    start(32'd81, 32'd4);
    wait_drain(60);
    start(32'd300, 32'd11, 4);
    wait_drain(60);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      start(ra, rb);
      wait_drain(60);
    end

    // Reset mid-RUN aborts with no RDY and clears the outputs.
    start(32'd100, 32'd7);
    idle(13);
    #2 reset_n = 1'b0;
    sbq.delete();
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_remainder", data_remainder, 32'd0);
    chk("abort_exception", {31'd0, data_exception}, 32'd0);
    idle(2);
    #2 reset_n = 1'b1;
    idle(45);
    chk("post_reset_result", data_result, 32'd0);
    chk("post_reset_remainder", data_remainder, 32'd0);
    chk("post_reset_rdy", {31'd0, data_resultRDY}, 32'd0);

    start(32'd144, 32'd12);
    wait_drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
